// File: rtl/hazard_scoreboard.sv
// Load-use stall detection and bypass select for a 5-stage pipeline; tracks EX/MEM/WB destinations.
// Stall/Forward/PipeEmpty are combinational; Freeze holds all state, reset is synchronous and dominant.
module hazard_scoreboard #(
  parameter int REG_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ReadRegister1,
  input  logic [REG_W-1:0] ReadRegister2,
  input  logic [REG_W-1:0] WriteRegister,
  input  logic             IsLoad,
  input  logic             IdValid,
  input  logic             Flush,
  input  logic             Freeze,
  output logic             Stall,
  output logic [1:0]       Forward1,
  output logic [1:0]       Forward2,
  output logic             PipeEmpty,
  output logic [CNT_W-1:0] StallCount
);

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             load;
    logic             valid;
  } entry_t;

  entry_t           ex_q, ex_d, mem_q, wb_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic hit(input logic [REG_W-1:0] src, input entry_t e);
    return e.valid && (src != '0) && (e.dest == src);
  endfunction

  // A load still in EX has no data yet, so it shadows any older producer.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src, input entry_t ex,
                                         input entry_t mem, input entry_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (hit(src, ex))       sel = ex.load ? 2'b00 : 2'b01;
    else if (hit(src, mem)) sel = 2'b10;
    else if (hit(src, wb))  sel = 2'b11;
    return sel;
  endfunction

  always_comb begin
    Stall     = IdValid && ex_q.load && (hit(ReadRegister1, ex_q) || hit(ReadRegister2, ex_q));
    Forward1  = fwd_sel(ReadRegister1, ex_q, mem_q, wb_q);
    Forward2  = fwd_sel(ReadRegister2, ex_q, mem_q, wb_q);
    PipeEmpty = !(ex_q.valid || mem_q.valid || wb_q.valid);

    ex_d = '0;
    if (IdValid && !Stall && !Flush) begin
      ex_d.dest  = WriteRegister;
      ex_d.load  = IsLoad;
      ex_d.valid = (WriteRegister != '0);
    end

    cnt_d = cnt_q;
    if (Stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else if (!Freeze) begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      cnt_q <= cnt_d;
    end
  end

  assign StallCount = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against an issue-history model.
module tb_hazard_scoreboard;
  localparam int RW   = 6;
  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] ReadRegister1, ReadRegister2, WriteRegister;
  logic          IsLoad, IdValid, Flush, Freeze;
  logic          Stall, PipeEmpty;
  logic [1:0]    Forward1, Forward2;
  logic [CW-1:0] StallCount;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [RW-1:0] dest;
    bit            load;
    bit            valid;
  } instr_t;

  // hist[0] is the youngest in-flight instruction (EX), hist[2] the oldest (WB).
  instr_t hist[$];
  int     m_cnt;

  hazard_scoreboard #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister), .IsLoad(IsLoad), .IdValid(IdValid),
    .Flush(Flush), .Freeze(Freeze),
    .Stall(Stall), .Forward1(Forward1), .Forward2(Forward2),
    .PipeEmpty(PipeEmpty), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    instr_t b;
    b = '{dest: '0, load: 1'b0, valid: 1'b0};
    hist = '{b, b, b};
    m_cnt = 0;
  endfunction

  function automatic bit uses(logic [RW-1:0] src, instr_t e);
    return e.valid && src != 0 && e.dest == src;
  endfunction

  function automatic bit exp_stall();
    return IdValid && hist[0].load && (uses(ReadRegister1, hist[0]) || uses(ReadRegister2, hist[0]));
  endfunction

  function automatic logic [1:0] exp_fwd(logic [RW-1:0] src);
    for (int i = 0; i < 3; i++)
      if (uses(src, hist[i])) begin
        if (i == 0) return hist[0].load ? 2'd0 : 2'd1;
        return (i == 1) ? 2'd2 : 2'd3;
      end
    return 2'd0;
  endfunction

  function automatic bit exp_empty();
    return !(hist[0].valid || hist[1].valid || hist[2].valid);
  endfunction

  task automatic drive(bit v, logic [RW-1:0] r1, logic [RW-1:0] r2, logic [RW-1:0] wr,
                       bit ld, bit fl, bit fz);
    IdValid = v; ReadRegister1 = r1; ReadRegister2 = r2; WriteRegister = wr;
    IsLoad = ld; Flush = fl; Freeze = fz; rst = 1'b0;
    #1;
  endtask

  task automatic tick();
    bit     st;
    instr_t n;
    st = exp_stall();
    @(posedge clk);
    if (rst) model_clear();
    else if (!Freeze) begin
      if (st && m_cnt < CMAX) m_cnt++;
      n = '{dest: '0, load: 1'b0, valid: 1'b0};
      if (IdValid && !st && !Flush) n = '{dest: WriteRegister, load: IsLoad, valid: WriteRegister != 0};
      hist.push_front(n);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 1, 1);
    rst = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", Stall); end
    checks++; if (Forward1 !== 2'b00 || Forward2 !== 2'b00) begin failures++; $display("FAIL reset_fwd got=%b/%b exp=00/00", Forward1, Forward2); end
    checks++; if (PipeEmpty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", PipeEmpty); end
    checks++; if (StallCount !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", StallCount); end
  endtask

  task automatic test_alu_chain();
    logic [1:0] exp_sel[4];
    exp_sel = '{2'b01, 2'b10, 2'b11, 2'b00};
    do_reset();
    drive(1, 0, 0, 8, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 8, 0, 0, 0, 0, 0);
      checks++;
      if (Forward1 !== exp_sel[i] || Stall !== 1'b0)
        begin failures++; $display("FAIL alu_chain_%0d fwd1=%b stall=%b exp fwd1=%b stall=0", i, Forward1, Stall, exp_sel[i]); end
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 9, 1, 0, 0);
    tick();
    drive(1, 0, 9, 0, 0, 0, 0);
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL load_use_stall got=%b exp=1", Stall); end
    checks++; if (Forward2 !== 2'b00) begin failures++; $display("FAIL load_use_fwd_ex got=%b exp=00", Forward2); end
    tick();
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL load_use_release got=%b exp=0", Stall); end
    checks++; if (Forward2 !== 2'b10) begin failures++; $display("FAIL load_use_fwd_mem got=%b exp=10", Forward2); end
    checks++; if (StallCount !== 10'd1) begin failures++; $display("FAIL load_use_count got=%0d exp=1", StallCount); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, i[0], 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    checks++; if (Forward1 !== 2'b00 || Stall !== 1'b0) begin failures++; $display("FAIL zero_reg fwd1=%b stall=%b exp 00/0", Forward1, Stall); end
    checks++; if (PipeEmpty !== 1'b1) begin failures++; $display("FAIL zero_reg_empty got=%b exp=1", PipeEmpty); end
  endtask

  task automatic test_hilo_priority();
    do_reset();
    drive(1, 0, 0, 33, 0, 0, 0);
    tick();
    drive(1, 33, 0, 0, 0, 0, 0);
    checks++; if (Forward1 !== 2'b01) begin failures++; $display("FAIL hilo_fwd got=%b exp=01", Forward1); end
    do_reset();
    drive(1, 0, 0, 8, 0, 0, 0); tick();
    drive(1, 0, 0, 8, 0, 0, 0); tick();
    drive(1, 8, 0, 0, 0, 0, 0);
    checks++; if (Forward1 !== 2'b01) begin failures++; $display("FAIL prio_ex_over_mem got=%b exp=01", Forward1); end
    do_reset();
    drive(1, 0, 0, 8, 0, 0, 0); tick();
    drive(1, 0, 0, 8, 1, 0, 0); tick();
    drive(0, 8, 0, 0, 0, 0, 0);
    checks++; if (Forward1 !== 2'b00 || Stall !== 1'b0) begin failures++; $display("FAIL load_shadow fwd1=%b stall=%b exp 00/0", Forward1, Stall); end
  endtask

  task automatic test_freeze();
    do_reset();
    drive(1, 0, 0, 9, 1, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 9, 0, 0, 0, 1);
      checks++;
      if (Stall !== 1'b1 || StallCount !== 10'd0 || Forward2 !== 2'b00 || PipeEmpty !== 1'b0)
        begin failures++; $display("FAIL freeze_hold_%0d stall=%b cnt=%0d fwd2=%b empty=%b exp 1/0/00/0", i, Stall, StallCount, Forward2, PipeEmpty); end
      tick();
    end
    drive(1, 0, 9, 0, 0, 0, 0);
    tick();
    checks++; if (StallCount !== 10'd1 || Stall !== 1'b0 || Forward2 !== 2'b10)
      begin failures++; $display("FAIL freeze_release cnt=%0d stall=%b fwd2=%b exp 1/0/10", StallCount, Stall, Forward2); end
  endtask

  task automatic test_flush_and_reset_stall();
    do_reset();
    drive(1, 0, 0, 9, 1, 0, 0); tick();
    drive(1, 0, 9, 5, 0, 1, 0); tick();
    checks++; if (StallCount !== 10'd1 || Forward2 !== 2'b10 || Forward1 !== 2'b00)
      begin failures++; $display("FAIL flush_stall cnt=%0d fwd2=%b fwd1=%b exp 1/10/00", StallCount, Forward2, Forward1); end
    drive(1, 0, 0, 9, 1, 0, 0); tick();
    drive(1, 9, 0, 0, 0, 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (Stall !== 1'b0 || StallCount !== 10'd0 || PipeEmpty !== 1'b1)
      begin failures++; $display("FAIL reset_mid_stall stall=%b cnt=%0d empty=%b exp 0/0/1", Stall, StallCount, PipeEmpty); end
  endtask

  task automatic test_random();
    logic [RW-1:0] pool[6];
    pool = '{6'd0, 6'd1, 6'd8, 6'd9, 6'd33, 6'd2};
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) != 0, pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
            pool[$urandom_range(0, 5)], $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      checks++;
      if (Stall !== exp_stall() || Forward1 !== exp_fwd(ReadRegister1) || Forward2 !== exp_fwd(ReadRegister2)
          || PipeEmpty !== exp_empty() || StallCount !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL random_%0d got stall=%b f1=%b f2=%b empty=%b cnt=%0d exp stall=%b f1=%b f2=%b empty=%b cnt=%0d",
                 i, Stall, Forward1, Forward2, PipeEmpty, StallCount,
                 exp_stall(), exp_fwd(ReadRegister1), exp_fwd(ReadRegister2), exp_empty(), m_cnt);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < CMAX; i++) begin
      drive(1, 0, 0, 9, 1, 0, 0); tick();
      drive(1, 9, 0, 0, 0, 0, 0); tick();
    end
    checks++; if (StallCount !== CW'(CMAX)) begin failures++; $display("FAIL sat_reach got=%0d exp=%0d", StallCount, CMAX); end
    drive(1, 0, 0, 9, 1, 0, 0); tick();
    drive(1, 9, 0, 0, 0, 0, 0);
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL sat_stall got=%b exp=1", Stall); end
    tick();
    checks++; if (StallCount !== CW'(CMAX)) begin failures++; $display("FAIL sat_hold got=%0d exp=%0d", StallCount, CMAX); end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (StallCount !== '0 || PipeEmpty !== 1'b1)
      begin failures++; $display("FAIL sat_reset cnt=%0d empty=%b exp 0/1", StallCount, PipeEmpty); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_zero_reg();
    test_hilo_priority();
    test_freeze();
    test_flush_and_reset_stall();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
